isu_rc_arbiter: RTL and testbench
=================================

# isu_rc_arbiter

Arbitrates the SRAM-controller request path between `NumReq` issue units (each an ISU slice with its own LSQ and refill buffer) and drives the single `d_rc_*` port of the SRAM controller. The block uses two priority classes: refill-buffer hits first, ordinary requests second. Each class has its own round-robin pointer, and a starvation counter guarantees the low class eventually wins. A one-entry output register decouples the requesters from `d_rc_ready`, and the block sustains one grant per cycle.

## Interface
- `NumReq`, 4: number of requesting issue units; range 2..8.
- `StarveMax`, 3: consecutive high-class grants allowed while a low-class request waits; range 1..15.
- `setWidth_t`, `wayIndexWidth_t`, `wbufWidth_t`, `robWidth_t`, logic: payload field types, identical to the ISU types.
- `clk` in 1: clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `req_valid` in [NumReq]: request valid per unit.
- `req_ready` out [NumReq]: request accepted this cycle; combinational; one-hot or zero.
- `req_op` in [NumReq][3]: operation code.
- `req_rob_id` in [NumReq] robWidth_t: reorder-buffer id.
- `req_set` in [NumReq] setWidth_t: target set.
- `req_way` in [NumReq] wayIndexWidth_t: target way.
- `req_wbuf_id` in [NumReq] wbufWidth_t: write-buffer id.
- `req_hit_refill_buf` in [NumReq]: the request carries refill data; selects the high class.
- `req_refill_data` in [NumReq][128]: refill line data.
- `d_rc_valid` out 1: output register valid.
- `d_rc_ready` in 1: SRAM controller accepts.
- `d_rc_src_1hot` out [NumReq]: one-hot index of the granted unit.
- `d_rc_op`, `d_rc_rob_id`, `d_rc_set`, `d_rc_way`, `d_rc_wbuf_id`, `d_rc_hit_refill_buf`, `d_rc_refill_data` out: registered payload of the granted request.

## Operation
- **Class split.**
  - hi = `req_valid & req_hit_refill_buf`.
  - lo = `req_valid & ~req_hit_refill_buf`.
- **Slot free.** `free = ~d_rc_valid | d_rc_ready`.
  - No grant is issued unless `free` is high.
  - When `free` is high and any request is valid, exactly one grant is issued.
- **Class select.**
  - The low class wins when lo is nonzero and either hi is zero or `starve_cnt == StarveMax`.
  - Otherwise the high class wins.
- **Round-robin.**
  - Each class has its own pointer (`rr_hi`, `rr_lo`, width clog2(NumReq)).
  - The winner is the first valid index in the selected class searching upward from the pointer, wrapping at NumReq-1 to 0.
  - On a grant to index i, that class's pointer becomes (i+1) mod NumReq; the other pointer is unchanged.
- **Starvation counter.** `starve_cnt` is 4 bits.
  - Increments when there is a high-class grant and lo is nonzero.
  - Clears on a low-class grant, or in any cycle where lo is zero.
  - Never exceeds StarveMax.
- **Capture.**
  - On a grant, the payload of unit i loads into the output register, `d_rc_src_1hot = 1<<i`, and `d_rc_valid` is set.
  - Without a grant, `d_rc_valid` clears on `d_rc_ready`; otherwise it holds.
- **Payload stability.** While `d_rc_valid & ~d_rc_ready`, all `d_rc_*` outputs hold stable.
- **Requester side.** Requesters may drop or change `req_valid` and payload freely; only the cycle of `req_ready` matters.
- **Combinational dependence.** `req_ready` depends combinationally on `d_rc_ready`. There is no path from `req_*` to `d_rc_*` within the same cycle.

## Timing
- **Latency.** Accept at edge N gives `d_rc_valid` high in cycle N+1.
- **Throughput.** One request per cycle when `d_rc_ready` is held high.
- **Reset values.**
  - `d_rc_valid` = 0, `req_ready` = 0.
  - All `d_rc_*` payload and `d_rc_src_1hot` = 0.
  - `rr_hi` = `rr_lo` = 0, `starve_cnt` = 0.
- **Reset mid-operation.** A held output entry is discarded without handshake. The first grant is possible in the first cycle with `rst_n` high.
- **Back-pressure.** With `d_rc_valid=1` and `d_rc_ready=0`, all `req_ready` are 0 and the pointers and counter are frozen.
- **Simultaneous dequeue and grant.** `d_rc_ready=1` with a valid request: the old entry leaves and the new entry loads at the same edge.
- **Stall with no demand.** `starve_cnt` holds when there is no grant and lo is nonzero.

## Test plan
- **Back-to-back round-robin.**
  - Stimulus: NumReq=4, all four units present lo requests continuously, `d_rc_ready=1`.
  - Required response: grants 0,1,2,3,0 on consecutive cycles; `d_rc_valid` continuous from cycle 1.
- **Starvation guard.**
  - Stimulus: unit 1 holds a hi request continuously, unit 2 holds a lo request, StarveMax=3.
  - Required response: grants 1,1,1,2,1,1,1,2; `starve_cnt` reads 0,1,2,3,0.
- **Back-pressure.**
  - Stimulus: grant unit 3 (set=0x5A), then `d_rc_ready=0` for 4 cycles.
  - Required response: `d_rc_set` stays 0x5A and `d_rc_src_1hot` stays 4'b1000; `req_ready` is 0 for all units; the next grant occurs in the cycle `d_rc_ready` rises.
- **Pointer wrap and class independence.**
  - Stimulus: `rr_lo`=3 with lo on units 0 and 3; then a hi grant to unit 2.
  - Required response: lo grants 3 then 0; `rr_hi` becomes 3; `rr_lo` is unaffected by the hi grant.
- **Refill payload.**
  - Stimulus: unit 0 hi request with `req_refill_data`=128'hDEAD_BEEF_...; unit 1 lo request in the same cycle.
  - Required response: unit 0 is granted first; `d_rc_hit_refill_buf`=1 and the 128-bit data matches exactly.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n=0` while `d_rc_valid=1` and `d_rc_ready=0`.
  - Required response: next cycle `d_rc_valid=0`, pointers and counter 0; after release, unit 0 wins a 4-way lo contention.

Source files
------------

// File: rtl/isu_rc_arbiter.sv
// isu_rc_arbiter: two-class round-robin arbiter feeding a one-entry SRAM-controller request register
module isu_rc_arbiter #(
  parameter int NumReq = 4,
  parameter int StarveMax = 3,
  parameter type setWidth_t = logic,
  parameter type wayIndexWidth_t = logic,
  parameter type wbufWidth_t = logic,
  parameter type robWidth_t = logic
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NumReq-1:0]     req_valid,
  output logic [NumReq-1:0]     req_ready,
  input  logic [2:0]            req_op [NumReq],
  input  robWidth_t             req_rob_id [NumReq],
  input  setWidth_t             req_set [NumReq],
  input  wayIndexWidth_t        req_way [NumReq],
  input  wbufWidth_t            req_wbuf_id [NumReq],
  input  logic [NumReq-1:0]     req_hit_refill_buf,
  input  logic [127:0]          req_refill_data [NumReq],
  output logic                  d_rc_valid,
  input  logic                  d_rc_ready,
  output logic [NumReq-1:0]     d_rc_src_1hot,
  output logic [2:0]            d_rc_op,
  output robWidth_t             d_rc_rob_id,
  output setWidth_t             d_rc_set,
  output wayIndexWidth_t        d_rc_way,
  output wbufWidth_t            d_rc_wbuf_id,
  output logic                  d_rc_hit_refill_buf,
  output logic [127:0]          d_rc_refill_data
);
  localparam int PW = $clog2(NumReq);
  logic [NumReq-1:0] hi, lo, cls;
  logic [PW-1:0] rr_hi, rr_lo, ptr, win, nxt;
  logic [3:0] starve_cnt;
  logic free, sel_lo, gnt;
  always_comb begin
    hi = req_valid & req_hit_refill_buf;
    lo = req_valid & ~req_hit_refill_buf;
    free = ~d_rc_valid | d_rc_ready;
    sel_lo = |lo && (~|hi || starve_cnt == 4'(StarveMax));
    cls = sel_lo ? lo : hi;
    ptr = sel_lo ? rr_lo : rr_hi;
    win = '0;
    // scan farthest-first so the index nearest the pointer is the last one written
    for (int k = NumReq - 1; k >= 0; k--)
      if (cls[(int'(ptr) + k) % NumReq]) win = PW'((int'(ptr) + k) % NumReq);
    nxt = (int'(win) == NumReq - 1) ? '0 : win + PW'(1);
    gnt = rst_n & free & |cls;
    req_ready = gnt ? NumReq'(1) << win : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_hi <= '0;
      rr_lo <= '0;
      starve_cnt <= '0;
      d_rc_valid <= 1'b0;
      d_rc_src_1hot <= '0;
      d_rc_op <= '0;
      d_rc_rob_id <= '0;
      d_rc_set <= '0;
      d_rc_way <= '0;
      d_rc_wbuf_id <= '0;
      d_rc_hit_refill_buf <= 1'b0;
      d_rc_refill_data <= '0;
    end else begin
      if (gnt) begin
        if (sel_lo) rr_lo <= nxt;
        else rr_hi <= nxt;
        d_rc_valid <= 1'b1;
        d_rc_src_1hot <= req_ready;
        d_rc_op <= req_op[win];
        d_rc_rob_id <= req_rob_id[win];
        d_rc_set <= req_set[win];
        d_rc_way <= req_way[win];
        d_rc_wbuf_id <= req_wbuf_id[win];
        d_rc_hit_refill_buf <= req_hit_refill_buf[win];
        d_rc_refill_data <= req_refill_data[win];
      end else if (d_rc_ready) begin
        d_rc_valid <= 1'b0;
      end
      starve_cnt <= (~|lo || (gnt && sel_lo)) ? '0 :
                    (gnt && starve_cnt < 4'(StarveMax)) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
endmodule

// File: tb/tb_isu_rc_arbiter.sv
// tb_isu_rc_arbiter: table-driven and directed checks of the two-class request arbiter
module tb_isu_rc_arbiter;
  typedef logic [7:0] set_t;
  typedef logic [1:0] way_t;
  typedef logic [2:0] wbuf_t;
  typedef logic [4:0] rob_t;
  typedef struct {
    logic [3:0] valid, hit;
    logic       rdy;
    logic [3:0] exp_ready, exp_cnt;
    logic       exp_v;
    logic [3:0] exp_src;
  } vec_t;
  logic clk, rst_n, d_rc_ready, d_rc_valid, d_rc_hit_refill_buf;
  logic [3:0] req_valid, req_ready, req_hit_refill_buf, d_rc_src_1hot;
  logic [2:0] req_op [4];
  rob_t req_rob_id [4];
  set_t req_set [4];
  way_t req_way [4];
  wbuf_t req_wbuf_id [4];
  logic [127:0] req_refill_data [4];
  logic [2:0] d_rc_op;
  rob_t d_rc_rob_id;
  set_t d_rc_set;
  way_t d_rc_way;
  wbuf_t d_rc_wbuf_id;
  logic [127:0] d_rc_refill_data;
  int n_chk = 0, n_fail = 0;
  vec_t tbl[$];
  localparam logic [127:0] Refill = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;

  isu_rc_arbiter #(.NumReq(4), .StarveMax(3), .setWidth_t(set_t), .wayIndexWidth_t(way_t),
                   .wbufWidth_t(wbuf_t), .robWidth_t(rob_t)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rob_id(req_rob_id), .req_set(req_set), .req_way(req_way), .req_wbuf_id(req_wbuf_id),
    .req_hit_refill_buf(req_hit_refill_buf), .req_refill_data(req_refill_data),
    .d_rc_valid(d_rc_valid), .d_rc_ready(d_rc_ready), .d_rc_src_1hot(d_rc_src_1hot),
    .d_rc_op(d_rc_op), .d_rc_rob_id(d_rc_rob_id), .d_rc_set(d_rc_set), .d_rc_way(d_rc_way),
    .d_rc_wbuf_id(d_rc_wbuf_id), .d_rc_hit_refill_buf(d_rc_hit_refill_buf),
    .d_rc_refill_data(d_rc_refill_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] va, input logic [3:0] hi, input logic rdy);
    req_valid = va;
    req_hit_refill_buf = hi;
    d_rc_ready = rdy;
  endtask

  task automatic set_default;
    for (int i = 0; i < 4; i++) begin
      req_op[i] = 3'(i);
      req_rob_id[i] = 5'(i + 8);
      req_set[i] = 8'(8'h10 + i);
      req_way[i] = 2'(i);
      req_wbuf_id[i] = 3'(i);
      req_refill_data[i] = {4{32'(i)}};
    end
  endtask

  function automatic vec_t mk(logic [3:0] va, logic [3:0] hi, logic r, logic [3:0] er,
                              logic [3:0] ec, logic ev, logic [3:0] es);
    vec_t v;
    v.valid = va; v.hit = hi; v.rdy = r; v.exp_ready = er;
    v.exp_cnt = ec; v.exp_v = ev; v.exp_src = es;
    return v;
  endfunction

  function automatic int oh2i(logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) tbl.push_back(mk(4'hF, 4'h0, 1'b1, 4'(1 << i), 4'd0, 1'b1, 4'(1 << i)));
    tbl.push_back(mk(4'hF, 4'h0, 1'b1, 4'b0001, 4'd0, 1'b1, 4'b0001));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(4'b0110, 4'b0010, 1'b1, (k % 4 == 3) ? 4'b0100 : 4'b0010, 4'(k % 4),
                       1'b1, (k % 4 == 3) ? 4'b0100 : 4'b0010));
    tbl.push_back(mk(4'h0, 4'h0, 1'b1, 4'h0, 4'd0, 1'b0, 4'h0));
    set_default;
    rst_n = 1'b0;
    drive(4'hF, 4'h0, 1'b1);
    repeat (2) tick;
    chk("reset req_ready", req_ready, 4'h0);
    chk("reset d_rc_valid", d_rc_valid, 1'b0);
    chk("reset src", d_rc_src_1hot, 4'h0);
    chk("reset set", d_rc_set, 8'h0);
    chk("reset data", d_rc_refill_data, 128'h0);
    chk("reset ptrs", {dut.rr_hi, dut.rr_lo, dut.starve_cnt}, 8'h0);
    rst_n = 1'b1;
    foreach (tbl[j]) begin
      drive(tbl[j].valid, tbl[j].hit, tbl[j].rdy);
      #1;
      chk($sformatf("vec%0d req_ready", j), req_ready, tbl[j].exp_ready);
      chk($sformatf("vec%0d starve_cnt", j), dut.starve_cnt, tbl[j].exp_cnt);
      tick;
      chk($sformatf("vec%0d d_rc_valid", j), d_rc_valid, tbl[j].exp_v);
      if (tbl[j].exp_v) begin
        chk($sformatf("vec%0d src", j), d_rc_src_1hot, tbl[j].exp_src);
        chk($sformatf("vec%0d set", j), d_rc_set, 8'(8'h10 + oh2i(tbl[j].exp_src)));
        chk($sformatf("vec%0d rob", j), d_rc_rob_id, 5'(8 + oh2i(tbl[j].exp_src)));
      end
    end
    req_set[3] = 8'h5A;
    drive(4'b1000, 4'h0, 1'b1);
    #1 chk("bp grant ready", req_ready, 4'b1000);
    tick;
    chk("bp grant set", d_rc_set, 8'h5A);
    drive(4'hF, 4'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("bp%0d req_ready", c), req_ready, 4'h0);
      tick;
      chk($sformatf("bp%0d set", c), d_rc_set, 8'h5A);
      chk($sformatf("bp%0d src", c), d_rc_src_1hot, 4'b1000);
      chk($sformatf("bp%0d valid", c), d_rc_valid, 1'b1);
      chk($sformatf("bp%0d rr_lo/cnt", c), {dut.rr_lo, dut.starve_cnt}, 6'h0);
    end
    d_rc_ready = 1'b1;
    #1 chk("bp release ready", req_ready, 4'b0001);
    tick;
    chk("bp release src", d_rc_src_1hot, 4'b0001);
    chk("bp release set", d_rc_set, 8'h10);
    req_set[3] = 8'h13;
    drive(4'b0100, 4'h0, 1'b1);
    #1 chk("wrap setup ready", req_ready, 4'b0100);
    tick;
    chk("wrap rr_lo=3", dut.rr_lo, 2'd3);
    drive(4'b1001, 4'h0, 1'b1);
    #1 chk("wrap lo ready 3", req_ready, 4'b1000);
    tick;
    chk("wrap rr_lo=0", dut.rr_lo, 2'd0);
    #1 chk("wrap lo ready 0", req_ready, 4'b0001);
    tick;
    chk("wrap src 0", d_rc_src_1hot, 4'b0001);
    drive(4'b0100, 4'b0100, 1'b1);
    #1 chk("hi grant ready", req_ready, 4'b0100);
    tick;
    chk("hi rr_hi=3", dut.rr_hi, 2'd3);
    chk("hi rr_lo kept", dut.rr_lo, 2'd1);
    chk("hi src", d_rc_src_1hot, 4'b0100);
    req_refill_data[0] = Refill;
    drive(4'b0011, 4'b0001, 1'b1);
    #1 chk("refill ready", req_ready, 4'b0001);
    tick;
    chk("refill src", d_rc_src_1hot, 4'b0001);
    chk("refill hit", d_rc_hit_refill_buf, 1'b1);
    chk("refill data", d_rc_refill_data, Refill);
    drive(4'b0010, 4'h0, 1'b1);
    #1 chk("after refill ready", req_ready, 4'b0010);
    tick;
    chk("after refill hit", d_rc_hit_refill_buf, 1'b0);
    chk("after refill data", d_rc_refill_data, {4{32'd1}});
    drive(4'hF, 4'h0, 1'b0);
    #1 chk("pre-reset hold ready", req_ready, 4'h0);
    tick;
    rst_n = 1'b0;
    #1 chk("in-reset ready", req_ready, 4'h0);
    tick;
    chk("mid reset valid", d_rc_valid, 1'b0);
    chk("mid reset ptrs", {dut.rr_hi, dut.rr_lo, dut.starve_cnt}, 8'h0);
    chk("mid reset src", d_rc_src_1hot, 4'h0);
    rst_n = 1'b1;
    #1 chk("post reset ready", req_ready, 4'b0001);
    tick;
    chk("post reset src", d_rc_src_1hot, 4'b0001);
    chk("post reset valid", d_rc_valid, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
